// File: rtl/usb_pkt_tx.sv
`default_nettype none
// ============================================================================
// Module      : usb_pkt_tx
// Description : Transmit packet assembler feeding the SIE. Builds PID-only
//               handshake packets and PID + payload + CRC16 data packets,
//               streaming them byte-by-byte over tx_data/tx_valid/tx_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_pkt_tx #(
    parameter int LEN_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pkt_start,
    input  logic [3:0]       pkt_pid,
    input  logic [LEN_W-1:0] pkt_len,
    output logic             pkt_busy,
    output logic             pkt_done,
    output logic [LEN_W-1:0] pld_addr,
    input  logic [7:0]       pld_data,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    input  logic             tx_active
);

    localparam logic [2:0] IDLE_S   = 3'd0;
    localparam logic [2:0] GAP_S    = 3'd1;
    localparam logic [2:0] PID_S    = 3'd2;
    localparam logic [2:0] DATA_S   = 3'd3;
    localparam logic [2:0] CRC_LO_S = 3'd4;
    localparam logic [2:0] CRC_HI_S = 3'd5;
    localparam logic [2:0] EOP_S    = 3'd6;

    localparam logic [15:0]      c_CRC_INIT = 16'hFFFF;
    localparam logic [15:0]      c_CRC_POLY = 16'hA001;
    localparam logic [LEN_W-1:0] c_ADDR_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W:0]   c_CNT_ONE  = {{LEN_W{1'b0}}, 1'b1};

    logic [2:0]       r_state;
    logic [3:0]       r_pid;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W:0]   r_cnt;
    logic [15:0]      r_crc;
    logic             r_seen_active;
    logic             r_pkt_busy;
    logic             r_pkt_done;
    logic [LEN_W-1:0] r_pld_addr;
    logic [7:0]       r_tx_data;
    logic             r_tx_valid;

    logic             w_hs;
    logic             w_is_data;
    logic             w_launch;
    logic [3:0]       w_launch_pid;

    // Reflected CRC16 (0xA001) update for one byte, LSB first.
    function automatic logic [15:0] f_crc_fold(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ c_CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    // Handshake qualifier, packet type, and the condition that raises tx_valid with the PID.
    always_comb begin
        w_hs         = r_tx_valid & tx_ready;
        w_is_data    = (r_pid[1:0] == 2'b11);
        w_launch     = ((r_state == IDLE_S) & pkt_start & ~tx_active) |
                       ((r_state == GAP_S) & ~tx_active);
        w_launch_pid = (r_state == IDLE_S) ? pkt_pid : r_pid;
    end

    // Packet sequencer: state, byte stream, buffer address, CRC and status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE_S;
            r_pid         <= 4'h0;
            r_len         <= '0;
            r_cnt         <= '0;
            r_crc         <= c_CRC_INIT;
            r_seen_active <= 1'b0;
            r_pkt_busy    <= 1'b0;
            r_pkt_done    <= 1'b0;
            r_pld_addr    <= '0;
            r_tx_data     <= 8'h00;
            r_tx_valid    <= 1'b0;
        end else begin
            r_pkt_done <= 1'b0;
            // Remember that the SIE actually started this packet, so EOP_S
            // does not exit before transmission has begun.
            if ((r_state != IDLE_S) && (r_state != GAP_S) && tx_active) begin
                r_seen_active <= 1'b1;
            end

            case (r_state)
                IDLE_S: begin
                    if (pkt_start) begin
                        r_pid      <= pkt_pid;
                        r_len      <= pkt_len;
                        r_pkt_busy <= 1'b1;
                        r_state    <= tx_active ? GAP_S : PID_S;
                    end
                end
                GAP_S: begin
                    if (!tx_active) begin
                        r_state <= PID_S;
                    end
                end
                PID_S: begin
                    if (w_hs) begin
                        if (!w_is_data) begin
                            r_tx_valid <= 1'b0;
                            r_state    <= EOP_S;
                        end else if (r_len == '0) begin
                            r_tx_data <= ~r_crc[7:0];
                            r_state   <= CRC_LO_S;
                        end else begin
                            r_tx_data  <= pld_data;
                            r_pld_addr <= c_ADDR_ONE;
                            r_crc      <= f_crc_fold(r_crc, pld_data);
                            r_cnt      <= c_CNT_ONE;
                            r_state    <= DATA_S;
                        end
                    end
                end
                DATA_S: begin
                    if (w_hs) begin
                        if (r_cnt < {1'b0, r_len}) begin
                            r_tx_data  <= pld_data;
                            r_pld_addr <= r_pld_addr + 1'b1;
                            r_crc      <= f_crc_fold(r_crc, pld_data);
                            r_cnt      <= r_cnt + 1'b1;
                        end else begin
                            r_tx_data <= ~r_crc[7:0];
                            r_state   <= CRC_LO_S;
                        end
                    end
                end
                CRC_LO_S: begin
                    if (w_hs) begin
                        r_tx_data <= ~r_crc[15:8];
                        r_state   <= CRC_HI_S;
                    end
                end
                CRC_HI_S: begin
                    if (w_hs) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= EOP_S;
                    end
                end
                EOP_S: begin
                    if (!tx_active && r_seen_active) begin
                        r_pkt_done <= 1'b1;
                        r_pkt_busy <= 1'b0;
                        r_state    <= IDLE_S;
                    end
                end
                default: begin
                    r_state <= IDLE_S;
                end
            endcase

            // Present the PID byte and rewind payload/CRC context; this
            // overrides the IDLE/GAP branch above only for fields it touches.
            if (w_launch) begin
                r_tx_valid    <= 1'b1;
                r_tx_data     <= {~w_launch_pid, w_launch_pid};
                r_pld_addr    <= '0;
                r_crc         <= c_CRC_INIT;
                r_seen_active <= 1'b0;
            end
        end
    end

    assign pkt_busy = r_pkt_busy;
    assign pkt_done = r_pkt_done;
    assign pld_addr = r_pld_addr;
    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;

endmodule
`default_nettype wire
